// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller and its datapath.
// Holds the FSM state encoding, the supported opcodes and every mux-select /
// ALU-op encoding the controller drives.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_BRANCH   = 4'd5,
    S_JUMP     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_R     = 4'd10,
    S_WB_I     = 4'd11,
    S_WB_MEM   = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  // opcodes (instruction[31:26])
  localparam int OP_R    = 0;
  localparam int OP_J    = 2;
  localparam int OP_JAL  = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_ADDI = 8;
  localparam int OP_SLTI = 10;
  localparam int OP_LW   = 35;
  localparam int OP_SW   = 43;

  // alu_op
  localparam logic [2:0] ALU_NONE   = 3'd0;
  localparam logic [2:0] ALU_R      = 3'd1;
  localparam logic [2:0] ALU_ADDI   = 3'd2;
  localparam logic [2:0] ALU_SLTI   = 3'd3;
  localparam logic [2:0] ALU_BEQ    = 3'd4;
  localparam logic [2:0] ALU_ADD_LW = 3'd5;
  localparam logic [2:0] ALU_ADD_SW = 3'd6;

  // alu_src_b
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // reg_dst
  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  // mem_to_reg
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  // pc_src
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Memory-wait timer: counts cycles a memory request spends waiting for ready.
// Ports:
//   clk, rst  clock / async active-high reset
//   active    a memory request is outstanding this cycle
//   ready     memory completes the request this cycle
//   clr       restart the count (ready or a state change)
//   expired   this is the last permitted wait cycle and ready is still low
// TIMEOUT=0 disables expiry.
module mc_mem_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // With TIMEOUT=0 the counter simply wraps; expiry is masked below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (!active || clr) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && active && !ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS-subset core.
// Sequences the shared ALU and unified memory port through
// FETCH/DECODE/EXEC/MEM/WB and drives all datapath selects and enables.
// Ports:
//   clk_i, rst_i          clock / async active-high reset
//   opcode_i, zero_i      IR opcode, ALU zero flag
//   mem_ready_i           memory completes current access
//   pc_write_o .. pc_src_o  datapath controls
//   retire_o, illegal_o   single-cycle event pulses
//   bus_err_o             sticky memory timeout flag (core halted)
//   state_o               current state, for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int OP_W    = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            ir_write_o,
  output logic            iord_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            reg_write_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [2:0]      alu_op_o,
  output logic [1:0]      reg_dst_o,
  output logic [1:0]      mem_to_reg_o,
  output logic [1:0]      pc_src_o,
  output logic            retire_o,
  output logic            illegal_o,
  output logic            bus_err_o,
  output logic [3:0]      state_o
);

  state_t state, next;
  logic   wait_active, expired, bus_err;

  function automatic logic is_op(input logic [OP_W-1:0] op, input int code);
    return op == OP_W'(code);
  endfunction

  assign wait_active = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mc_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .active  (wait_active),
    .ready   (mem_ready_i),
    .clr     (mem_ready_i || (next != state)),
    .expired (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      bus_err <= 1'b0;
    end else begin
      state   <= next;
      bus_err <= bus_err || (next == S_HALT);
    end
  end

  always_comb begin
    next         = state;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    alu_op_o     = ALU_NONE;
    reg_dst_o    = RDST_RT;
    mem_to_reg_o = M2R_ALU;
    pc_src_o     = PCS_ALU;
    retire_o     = 1'b0;
    illegal_o    = 1'b0;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_op_o    = ALU_ADD_LW;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          next       = S_DECODE;
        end else if (expired) begin
          next = S_HALT;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        alu_src_b_o = SRCB_IMM_SH;
        alu_op_o    = ALU_ADD_LW;
        if (is_op(opcode_i, OP_R))                                 next = S_EXEC_R;
        else if (is_op(opcode_i, OP_ADDI) || is_op(opcode_i, OP_SLTI)) next = S_EXEC_I;
        else if (is_op(opcode_i, OP_BEQ))                          next = S_BRANCH;
        else if (is_op(opcode_i, OP_LW) || is_op(opcode_i, OP_SW)) next = S_MEM_ADDR;
        else if (is_op(opcode_i, OP_J) || is_op(opcode_i, OP_JAL)) next = S_JUMP;
        else begin
          illegal_o = 1'b1;
          next      = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_R;
        next        = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = is_op(opcode_i, OP_SLTI) ? ALU_SLTI : ALU_ADDI;
        next        = S_WB_I;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_BEQ;
        pc_src_o    = PCS_ALUOUT;
        pc_write_o  = zero_i;
        retire_o    = 1'b1;
        next        = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o   = PCS_JUMP;
        pc_write_o = 1'b1;
        retire_o   = 1'b1;
        // jal links PC, which already holds PC+4 from FETCH.
        if (is_op(opcode_i, OP_JAL)) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = RDST_RA;
          mem_to_reg_o = M2R_PC;
        end
        next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        if (is_op(opcode_i, OP_SW)) begin
          alu_op_o = ALU_ADD_SW;
          next     = S_MEM_WR;
        end else begin
          alu_op_o = ALU_ADD_LW;
          next     = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
        if (mem_ready_i)  next = S_WB_MEM;
        else if (expired) next = S_HALT;
      end
      S_MEM_WR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          next     = S_FETCH;
        end else if (expired) begin
          next = S_HALT;
        end
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = RDST_RD;
        retire_o    = 1'b1;
        next        = S_FETCH;
      end
      S_WB_I: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        next        = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
        retire_o     = 1'b1;
        next         = S_FETCH;
      end
      S_HALT: next = S_HALT;
      default: next = S_FETCH;  // unused encodings recover
    endcase
  end

  assign bus_err_o = bus_err;
  assign state_o   = state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the single-issue MIPS-subset core: R-type, addi, slti, beq, lw, sw, j, jal.
- Sequences one shared ALU and one unified instruction/data memory port through FETCH/DECODE/EXEC/MEM/WB steps.
- Drives all datapath mux selects and write enables, plus a ready handshake with memory.
- Adds a memory-wait timeout that halts the core and reports a bus error.

Parameters:
TIMEOUT, 8, max cycles a memory access may wait for mem_ready_i; 0 disables the timeout
OP_W, 6, opcode width

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  asynchronous, active-high reset
opcode_i  in  6  instruction[31:26] from IR; stable from DECODE until next FETCH
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes the current read/write this cycle
pc_write_o  out  1  PC load enable
ir_write_o  out  1  IR load enable
iord_o  out  1  memory address select: 0=PC, 1=ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
reg_write_o  out  1  register file write enable
alu_src_a_o  out  1  ALU A select: 0=PC, 1=rs
alu_src_b_o  out  2  ALU B select: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op_o  out  3  ALU op code: 0 none, 1 R, 2 addi, 3 slti, 4 beq, 5 add (lw), 6 add (sw)
reg_dst_o  out  2  write register select: 0=rt, 1=rd, 2=$31
mem_to_reg_o  out  2  write data select: 0=ALUOut, 1=MDR, 2=PC
pc_src_o  out  2  PC source select: 0=ALU result, 1=ALUOut, 2=jump target
retire_o  out  1  one-cycle pulse when an instruction completes
illegal_o  out  1  one-cycle pulse on an unknown opcode
bus_err_o  out  1  sticky memory timeout flag
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (async, any time including mid-access):
  - state=IDLE(0), wait counter=0, bus_err_o=0.
  - Every output is 0 in IDLE.
  - IDLE always moves to FETCH on the next edge.
- Outputs are decoded combinationally from state, opcode_i, zero_i and mem_ready_i. Any output not listed for a state is 0.
- FETCH(1): mem_read=1, iord=0, src_a=0, src_b=1, alu_op=5, pc_src=0.
  - On mem_ready_i: ir_write=1, pc_write=1, go to DECODE.
- DECODE(2): src_a=0, src_b=3, alu_op=5 (branch target into ALUOut). Dispatch on opcode:
  - 0 -> EXEC_R
  - 8 or 10 -> EXEC_I
  - 4 -> BRANCH
  - 35 or 43 -> MEM_ADDR
  - 2 or 3 -> JUMP
  - any other opcode -> illegal_o=1 this cycle, then FETCH; nothing is written.
- EXEC_R(3): src_a=1, src_b=0, alu_op=1 -> WB_R.
- EXEC_I(4): src_a=1, src_b=2, alu_op=2 (opcode 8) or 3 (opcode 10) -> WB_I.
- BRANCH(5): src_a=1, src_b=0, alu_op=4, pc_src=1, pc_write=zero_i, retire=1 -> FETCH.
- JUMP(6): pc_src=2, pc_write=1, retire=1 -> FETCH.
  - If opcode=3 (jal), also reg_write=1, reg_dst=2, mem_to_reg=2. PC already holds PC+4 here.
- MEM_ADDR(7): src_a=1, src_b=2, alu_op=5 (lw) or 6 (sw) -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD(8): iord=1, mem_read=1. On mem_ready_i -> WB_MEM.
- MEM_WR(9): iord=1, mem_write=1. On mem_ready_i: retire=1 -> FETCH.
- WB_R(10): reg_write=1, reg_dst=1, mem_to_reg=0, retire=1 -> FETCH.
- WB_I(11): reg_write=1, reg_dst=0, mem_to_reg=0, retire=1 -> FETCH.
- WB_MEM(12): reg_write=1, reg_dst=0, mem_to_reg=1, retire=1 -> FETCH.
- HALT(15): every output 0 except bus_err_o=1. Left only by reset.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Counts cycles with mem_ready_i=0.
  - Cleared on mem_ready_i and on every state change.
  - If mem_ready_i=0 while counter==TIMEOUT-1: go to HALT and set bus_err_o. No request is asserted after that.
  - mem_ready_i in that same cycle wins over the timeout.
- Cycle counts with zero-wait memory:
  - beq, j, jal: 3 cycles.
  - R-type, addi, slti, sw: 4 cycles.
  - lw: 5 cycles.
- States 13 and 14 are unused; if ever entered, go to FETCH.

Decomposition:
- Shared package holds: state encodings; opcode constants (R=0, J=2, JAL=3, BEQ=4, ADDI=8, SLTI=10, LW=35, SW=43); alu_op, src_b, reg_dst, mem_to_reg and pc_src encodings. The datapath uses the same encodings.
- One natural sub-module: mc_mem_wait_timer (counter, clear, TIMEOUT compare, timeout strobe).

Test Plan:
- Reset: assert rst_i mid-MEM_RD -> same cycle state_o=0 and all outputs 0. Deassert -> next cycle state_o=1, mem_read_o=1.
- R-type, opcode 0, mem_ready_i=1 -> state_o sequence 1,2,3,10,1. reg_write_o=1 and reg_dst_o=1 only in 10. retire_o high exactly 1 cycle.
- lw, opcode 35, mem_ready_i low 3 cycles in MEM_RD -> state 8 held 4 cycles with iord_o=1. Then 12 with mem_to_reg_o=1. alu_op_o=5 in state 7.
- beq, opcode 4: zero_i=0 -> pc_write_o=0 in state 5; zero_i=1 -> pc_write_o=1 with pc_src_o=1. Both retire in cycle 3.
- jal, opcode 3 -> state 6 with pc_write_o=1, pc_src_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2. j (opcode 2) -> same but reg_write_o=0.
- Opcode 63 -> illegal_o pulses in state 2, then state 1. Then mem_ready_i held low in FETCH with TIMEOUT=8 -> HALT (15) after the 8th wait cycle, bus_err_o=1, held until rst_i.
